// File: rtl/multi_recv_controller_if.sv
// Bus bundle between the command controller and its UART / receiver-channel neighbours.
//   rx_out/rx_over          : byte and ready flag from uart_rx
//   recv_in/recv_write      : per-channel data bytes and strobes
//   tx_in/tx_write          : byte and write strobe to uart_tx
//   recv_en/recv_rst_n/level: per-channel enable, active-low reset, judge level
//   scode/scode_rdy         : last executed opcode (0xFF on NAK) and its update pulse
interface multi_recv_controller_if #(
  parameter int unsigned NCH = 4
);
  logic [7:0]       rx_out;
  logic             rx_over;
  logic [8*NCH-1:0] recv_in;
  logic [NCH-1:0]   recv_write;
  logic [7:0]       tx_in;
  logic             tx_write;
  logic [NCH-1:0]   recv_en;
  logic [NCH-1:0]   recv_rst_n;
  logic [8*NCH-1:0] level;
  logic [7:0]       scode;
  logic             scode_rdy;

  // Controller side
  modport master (
    input  rx_out, rx_over, recv_in, recv_write,
    output tx_in, tx_write, recv_en, recv_rst_n, level, scode, scode_rdy
  );

  // Environment side (UART and channels)
  modport slave (
    output rx_out, rx_over, recv_in, recv_write,
    input  tx_in, tx_write, recv_en, recv_rst_n, level, scode, scode_rdy
  );
endinterface

// File: rtl/multi_recv_controller.sv
// UART command controller for NCH receiver channels: parses commands from RX, drives
// per-channel enable/reset/level, sends ACK/NAK/status replies, and otherwise passes the
// selected channel's data through to TX.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : multi_recv_controller_if.master (UART and channel signals)
module multi_recv_controller #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned LEVEL_RST = 127,
  parameter int unsigned GAP       = 10000,
  parameter int unsigned TIMEOUT   = 100000,
  parameter int unsigned RST_CYC   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multi_recv_controller_if.master bus
);

  localparam int unsigned CW  = $clog2(TIMEOUT + GAP + 1);
  localparam int unsigned IW  = $clog2(NCH + 2);
  localparam int unsigned RW  = $clog2(RST_CYC + 1);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARG1, S_ARG2, S_EXEC, S_REPLY, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d, arg1_q, arg1_d, arg2_q, arg2_d;
  logic             tmo_q, tmo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d, nbytes_q, nbytes_d, nxt_idx;
  logic [7:0]       tx_in_q, tx_in_d;
  logic [NCH-1:0]   en_q, en_d, rst_n_q, rst_n_d, trig;
  logic [8*NCH-1:0] level_q, level_d;
  logic [CHW-1:0]   sel_q, sel_d;
  logic             silence_q, silence_d;
  logic [7:0]       scode_q, scode_d;
  logic             scode_rdy_q, scode_rdy_d;
  logic             rx_over_q;
  logic [RW-1:0]    rst_cnt_q [NCH];
  logic [RW-1:0]    rst_cnt_d [NCH];
  logic             byte_c, ch_ok, nak, owned_c;
  logic [7:0]       stat_byte, chan_data;

  assign byte_c = bus.rx_over & ~rx_over_q;
  assign ch_ok  = (arg1_q < 8'(NCH));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      arg1_q      <= '0;
      arg2_q      <= '0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      nbytes_q    <= '0;
      tx_in_q     <= '0;
      en_q        <= '0;
      rst_n_q     <= '1;
      level_q     <= {NCH{8'(LEVEL_RST)}};
      sel_q       <= '0;
      silence_q   <= 1'b0;
      scode_q     <= '0;
      scode_rdy_q <= 1'b0;
      rx_over_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) rst_cnt_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg1_q      <= arg1_d;
      arg2_q      <= arg2_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      nbytes_q    <= nbytes_d;
      tx_in_q     <= tx_in_d;
      en_q        <= en_d;
      rst_n_q     <= rst_n_d;
      level_q     <= level_d;
      sel_q       <= sel_d;
      silence_q   <= silence_d;
      scode_q     <= scode_d;
      scode_rdy_q <= scode_rdy_d;
      rx_over_q   <= bus.rx_over;
      for (int k = 0; k < NCH; k++) rst_cnt_q[k] <= rst_cnt_d[k];
    end
  end

  // Next status-reply byte: index 0 is the enable mask, index k+1 is level[k]
  always_comb begin
    nxt_idx   = idx_q + IW'(1);
    stat_byte = 8'(en_q);
    for (int k = 0; k < NCH; k++)
      if (nxt_idx == IW'(k + 1)) stat_byte = level_q[8*k +: 8];
  end

  // Command FSM: next state, command effects and reply sequencing
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    nbytes_d    = nbytes_q;
    tx_in_d     = tx_in_q;
    en_d        = en_q;
    level_d     = level_q;
    sel_d       = sel_q;
    silence_d   = silence_q;
    scode_d     = scode_q;
    scode_rdy_d = 1'b0;
    trig        = '0;
    nak         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_c) begin
          op_d  = bus.rx_out;
          tmo_d = 1'b0;
          cnt_d = '0;
          case (bus.rx_out)
            8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07: state_d = S_ARG1;
            default:                                  state_d = S_EXEC;
          endcase
        end
      end
      S_ARG1, S_ARG2: begin
        if (byte_c) begin
          cnt_d = '0;
          if (state_q == S_ARG1) begin
            arg1_d  = bus.rx_out;
            state_d = (op_q == 8'h06) ? S_ARG2 : S_EXEC;
          end else begin
            arg2_d  = bus.rx_out;
            state_d = S_EXEC;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        nak = tmo_q;
        if (!tmo_q) begin
          case (op_q)
            8'h01: begin
              nak = ~ch_ok;
              for (int k = 0; k < NCH; k++) if (ch_ok && arg1_q == 8'(k)) trig[k] = 1'b1;
            end
            8'h02, 8'h03: begin
              nak = ~ch_ok;
              for (int k = 0; k < NCH; k++)
                if (ch_ok && arg1_q == 8'(k)) en_d[k] = (op_q == 8'h02);
            end
            8'h04: ;
            8'h05: silence_d = arg1_q[0];
            8'h06: begin
              nak = ~ch_ok;
              for (int k = 0; k < NCH; k++)
                if (ch_ok && arg1_q == 8'(k)) level_d[8*k +: 8] = arg2_q;
            end
            8'h07: begin
              nak = ~ch_ok;
              if (ch_ok) sel_d = arg1_q[CHW-1:0];
            end
            default: nak = 1'b1;
          endcase
        end
        scode_rdy_d = 1'b1;
        idx_d       = '0;
        nbytes_d    = IW'(1);
        if (nak) begin
          scode_d = 8'hFF;
          tx_in_d = 8'h02;
        end else if (op_q == 8'h04) begin
          scode_d  = op_q;
          tx_in_d  = 8'(en_q);
          nbytes_d = IW'(NCH + 1);
        end else begin
          scode_d = op_q;
          tx_in_d = 8'h01;
        end
        state_d = S_REPLY;
      end
      S_REPLY: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        // GAP-1 idle cycles plus the REPLY cycle spaces strobes exactly GAP apart
        if (nxt_idx < nbytes_q) begin
          if (cnt_q == CW'(GAP - 2)) begin
            idx_d   = nxt_idx;
            tx_in_d = stat_byte;
            state_d = S_REPLY;
          end
        end else if (cnt_q == CW'(GAP - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Per-channel reset pulse counters; a new trigger restarts the count
    for (int k = 0; k < NCH; k++) begin
      if (trig[k])                rst_cnt_d[k] = RW'(RST_CYC);
      else if (rst_cnt_q[k] != 0) rst_cnt_d[k] = rst_cnt_q[k] - RW'(1);
      else                        rst_cnt_d[k] = '0;
      rst_n_d[k] = (rst_cnt_d[k] == '0);
    end
  end

  // Selected channel for pass-through
  always_comb begin
    chan_data = bus.recv_in[7:0];
    for (int k = 0; k < NCH; k++)
      if (sel_q == CHW'(k)) chan_data = bus.recv_in[8*k +: 8];
  end

  // Controller owns TX from the opcode byte until it is back in IDLE
  assign owned_c = (state_q != S_IDLE) | byte_c;

  assign bus.tx_in      = owned_c ? tx_in_q : chan_data;
  assign bus.tx_write   = owned_c ? (state_q == S_REPLY)
                                  : (bus.recv_write[sel_q] & ~silence_q);
  assign bus.recv_en    = en_q;
  assign bus.recv_rst_n = rst_n_q;
  assign bus.level      = level_q;
  assign bus.scode      = scode_q;
  assign bus.scode_rdy  = scode_rdy_q;

endmodule

// File: tb/tb_multi_recv_controller.sv
// Randomized self-checking bench for multi_recv_controller against a command-level model.
module tb_multi_recv_controller;

  localparam int unsigned NCH     = 4;
  localparam int unsigned LVL_RST = 127;
  localparam int unsigned GAP     = 8;
  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned RST_CYC = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  multi_recv_controller_if #(.NCH(NCH)) bus ();

  multi_recv_controller #(
    .NCH(NCH), .LEVEL_RST(LVL_RST), .GAP(GAP), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity
  logic [7:0] tx_q [$];
  int         tx_t [$];
  int         rdy_cnt;
  int         rstlow [NCH];

  always @(negedge clk) begin
    if (bus.tx_write) begin
      tx_q.push_back(bus.tx_in);
      tx_t.push_back(cyc);
    end
    if (bus.scode_rdy) rdy_cnt++;
    for (int k = 0; k < NCH; k++) if (!bus.recv_rst_n[k]) rstlow[k]++;
  end

  // Reference model state
  bit         m_en [NCH];
  logic [7:0] m_lvl [NCH];
  int         m_sel;
  bit         m_sil;
  logic [7:0] m_scode;
  logic [7:0] exp_q [$];
  int         exp_rst_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int argc_of(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h03, 8'h05, 8'h07: return 1;
      8'h06:                             return 2;
      default:                           return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_en_vec();
    logic [31:0] v = '0;
    for (int k = 0; k < NCH; k++) v[k] = m_en[k];
    return v;
  endfunction

  function automatic logic [31:0] m_lvl_vec();
    logic [31:0] v = '0;
    for (int k = 0; k < NCH; k++) v[8*k +: 8] = m_lvl[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_en[k]  = 1'b0;
      m_lvl[k] = 8'(LVL_RST);
    end
    m_sel   = 0;
    m_sil   = 1'b0;
    m_scode = 8'h00;
  endtask

  // Apply one command to the model and build the expected reply
  task automatic model_cmd(input logic [7:0] op, a1, a2, input bit tmo);
    bit nak;
    bit ch_bad;
    ch_bad = (int'(a1) >= NCH);
    nak = 1'b0;
    exp_rst_ch = -1;
    exp_q.delete();
    if (tmo) nak = 1'b1;
    else begin
      case (op)
        8'h01: if (ch_bad) nak = 1'b1; else exp_rst_ch = int'(a1);
        8'h02: if (ch_bad) nak = 1'b1; else m_en[int'(a1)] = 1'b1;
        8'h03: if (ch_bad) nak = 1'b1; else m_en[int'(a1)] = 1'b0;
        8'h04: ;
        8'h05: m_sil = a1[0];
        8'h06: if (ch_bad) nak = 1'b1; else m_lvl[int'(a1)] = a2;
        8'h07: if (ch_bad) nak = 1'b1; else m_sel = int'(a1);
        default: nak = 1'b1;
      endcase
    end
    if (nak) begin
      m_scode = 8'hFF;
      exp_q.push_back(8'h02);
    end else begin
      m_scode = op;
      if (op == 8'h04) begin
        exp_q.push_back(8'(m_en_vec()));
        for (int k = 0; k < NCH; k++) exp_q.push_back(m_lvl[k]);
      end else begin
        exp_q.push_back(8'h01);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_out  = b;
    bus.rx_over = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx_over = 1'b0;
    @(negedge clk);
  endtask

  // Send opcode plus (nsend-1) argument bytes, let the reply finish, compare with the model
  task automatic do_cmd(input logic [7:0] op, a1, a2, input int nsend);
    bit tmo;
    int wait_cyc;
    tmo = (nsend - 1) < argc_of(op);
    tx_q.delete();
    tx_t.delete();
    rdy_cnt = 0;
    for (int k = 0; k < NCH; k++) rstlow[k] = 0;
    send_byte(op);
    if (nsend >= 2) send_byte(a1);
    if (nsend >= 3) send_byte(a2);
    model_cmd(op, a1, a2, tmo);
    wait_cyc = (tmo ? TIMEOUT : 0) + GAP * (exp_q.size() + 1) + 10;
    repeat (wait_cyc) @(negedge clk);
    check("reply_len", tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
      check("reply_byte", tx_q[i], exp_q[i]);
      if (i > 0) check("reply_gap", tx_t[i] - tx_t[i-1], GAP);
    end
    check("scode", bus.scode, m_scode);
    check("scode_rdy_pulses", rdy_cnt, 1);
    check("recv_en", 32'(bus.recv_en), m_en_vec());
    check("level", 32'(bus.level), m_lvl_vec());
    check("recv_rst_n_idle", 32'(bus.recv_rst_n), 32'(NCH'('1)));
    for (int k = 0; k < NCH; k++)
      check("rst_low_cycles", rstlow[k], (k == exp_rst_ch) ? RST_CYC : 0);
  endtask

  task automatic pulse_chan(input int ch, input logic [7:0] d);
    @(negedge clk);
    bus.recv_in[8*ch +: 8] = d;
    bus.recv_write[ch]     = 1'b1;
    #1;
    check("pass_write", bus.tx_write, (ch == m_sel) && !m_sil);
    if (ch == m_sel && !m_sil) check("pass_data", bus.tx_in, d);
    @(negedge clk);
    bus.recv_write = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_recv_en", 32'(bus.recv_en), 0);
    check("rst_recv_rst_n", 32'(bus.recv_rst_n), 32'(NCH'('1)));
    check("rst_level", 32'(bus.level), {4{8'(LVL_RST)}});
    check("rst_scode", bus.scode, 0);
    check("rst_scode_rdy", bus.scode_rdy, 0);
    check("rst_tx_write", bus.tx_write, 0);
  endtask

  initial begin
    logic [7:0] op, a1, a2;
    int r, ns, budget;
    rst            = 1'b1;
    bus.rx_out     = '0;
    bus.rx_over    = 1'b0;
    bus.recv_in    = '0;
    bus.recv_write = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios
    do_cmd(8'h02, 8'h01, 8'h00, 2);
    do_cmd(8'h06, 8'h02, 8'h5A, 3);
    do_cmd(8'h06, 8'h02, 8'h33, 2);
    do_cmd(8'h03, 8'h01, 8'h00, 2);
    do_cmd(8'h02, 8'h00, 8'h00, 2);
    do_cmd(8'h02, 8'h03, 8'h00, 2);
    do_cmd(8'h06, 8'h02, 8'h7F, 3);
    do_cmd(8'h04, 8'h00, 8'h00, 1);
    do_cmd(8'h07, 8'h01, 8'h00, 2);
    pulse_chan(1, 8'hA5);
    pulse_chan(2, 8'h3C);
    do_cmd(8'h05, 8'h01, 8'h00, 2);
    pulse_chan(1, 8'hA5);
    do_cmd(8'h05, 8'h00, 8'h00, 2);
    do_cmd(8'h01, 8'h04, 8'h00, 2);
    do_cmd(8'h01, 8'h02, 8'h00, 2);
    do_cmd(8'h09, 8'h00, 8'h00, 1);
    do_cmd(8'h07, 8'h07, 8'h00, 2);

    // Randomized commands, including bad channels, unknown opcodes and arg timeouts
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      a1 = 8'($urandom_range(0, 5));
      a2 = 8'($urandom);
      if (r <= 6) op = 8'(r + 1);
      else if (r == 7) op = 8'($urandom_range(8, 255));
      else op = 8'h00;
      if (op == 8'h05) a1 = 8'($urandom);
      ns = 1 + argc_of(op);
      if (argc_of(op) > 0 && $urandom_range(0, 5) == 0) ns = $urandom_range(1, argc_of(op));
      do_cmd(op, a1, a2, ns);
      if ($urandom_range(0, 3) == 0) pulse_chan($urandom_range(0, NCH - 1), 8'($urandom));
    end

    // Reset in the middle of a STATUS reply aborts it
    do_cmd(8'h05, 8'h00, 8'h00, 2);
    do_cmd(8'h02, 8'h01, 8'h00, 2);
    tx_q.delete();
    send_byte(8'h04);
    budget = 0;
    while (tx_q.size() < 2 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("status_started", 32'(tx_q.size() >= 2), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    model_reset();
    tx_q.delete();
    repeat (6 * GAP) @(negedge clk);
    check("no_tx_after_rst", tx_q.size(), 0);
    do_cmd(8'h04, 8'h00, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
